// File: rtl/uart_seq_trig_if.sv
// uart_seq_trig_if: serial input, configuration and decoded/trigger outputs of uart_seq_trig.
// Parity controls exist only when UART_SEQ_TRIG_PARITY_EN is defined.
`timescale 1ns/1ps
interface uart_seq_trig_if #(
  parameter int DATA_W = 8,
  parameter int NMATCH = 2,
  parameter int BAUD_W = 16
);
  logic                     rx_i;
  logic [BAUD_W-1:0]        baud_cnt_i;
  logic [NMATCH*DATA_W-1:0] match_i;
  logic [NMATCH*DATA_W-1:0] mask_i;
  logic                     armed_i;
`ifdef UART_SEQ_TRIG_PARITY_EN
  logic                     parity_en_i;
  logic                     parity_odd_i;
`endif
  logic [DATA_W-1:0]        rx_data_o;
  logic                     byte_rdy_o;
  logic                     frm_err_o;
  logic                     triggered_o;
`ifdef UART_SEQ_TRIG_PARITY_EN
  modport master (output rx_i, baud_cnt_i, match_i, mask_i, armed_i, parity_en_i, parity_odd_i,
                  input rx_data_o, byte_rdy_o, frm_err_o, triggered_o);
  modport slave (input rx_i, baud_cnt_i, match_i, mask_i, armed_i, parity_en_i, parity_odd_i,
                 output rx_data_o, byte_rdy_o, frm_err_o, triggered_o);
`else
  modport master (output rx_i, baud_cnt_i, match_i, mask_i, armed_i,
                  input rx_data_o, byte_rdy_o, frm_err_o, triggered_o);
  modport slave (input rx_i, baud_cnt_i, match_i, mask_i, armed_i,
                 output rx_data_o, byte_rdy_o, frm_err_o, triggered_o);
`endif
endinterface

// File: rtl/uart_seq_trig.sv
// uart_seq_trig: oversampling UART receiver with a sticky trigger on a masked multi-word sequence.
// Define UART_SEQ_TRIG_PARITY_EN to add an optional parity bit between data and stop.
`timescale 1ns/1ps
module uart_seq_trig #(
  parameter int DATA_W = 8,
  parameter int NMATCH = 2,
  parameter int BAUD_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  uart_seq_trig_if.slave bus
);
  localparam int BW = $clog2(DATA_W);
  localparam int IW = NMATCH > 1 ? $clog2(NMATCH) : 1;
`ifdef UART_SEQ_TRIG_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t            state_q;
  logic              s1_q, s2_q, s3_q;
  logic [BAUD_W-1:0] baud_q, cnt_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] sr_q, sr_d, rx_data_q;
  logic              byte_rdy_q, frm_err_q;
  logic              trig_q, trig_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NMATCH-1:0] hit;
  logic              fall, tick, frame_ok;
`ifdef UART_SEQ_TRIG_PARITY_EN
  logic              par_en_q, par_odd_q, par_ok_q;
  assign frame_ok = s2_q & par_ok_q;
`else
  assign frame_ok = s2_q;
`endif
  assign fall = s3_q & ~s2_q;
  assign tick = cnt_q == '0;
  assign sr_d = {s2_q, sr_q[DATA_W-1:1]};
  // Idle-high reset values keep the line from looking like a start edge out of reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1_q, s2_q, s3_q} <= 3'b111;
    else {s1_q, s2_q, s3_q} <= {bus.rx_i, s1_q, s2_q};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      rx_data_q  <= '0;
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
`ifdef UART_SEQ_TRIG_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_ok_q   <= 1'b1;
`endif
    end else begin
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
      cnt_q      <= tick ? cnt_q : cnt_q - BAUD_W'(1);
      case (state_q)
        IDLE: if (fall) begin
          state_q <= START;
          baud_q  <= bus.baud_cnt_i;
          cnt_q   <= bus.baud_cnt_i >> 1;
`ifdef UART_SEQ_TRIG_PARITY_EN
          par_en_q  <= bus.parity_en_i;
          par_odd_q <= bus.parity_odd_i;
          par_ok_q  <= 1'b1;
`endif
        end
        START: if (tick) begin
          state_q <= s2_q ? IDLE : DATA;
          cnt_q   <= baud_q - BAUD_W'(1);
          bit_q   <= '0;
        end
        DATA: if (tick) begin
          sr_q  <= sr_d;
          bit_q <= bit_q + BW'(1);
          cnt_q <= baud_q - BAUD_W'(1);
`ifdef UART_SEQ_TRIG_PARITY_EN
          if (bit_q == BW'(DATA_W - 1)) state_q <= par_en_q ? PARITY : STOP;
`else
          if (bit_q == BW'(DATA_W - 1)) state_q <= STOP;
`endif
        end
`ifdef UART_SEQ_TRIG_PARITY_EN
        PARITY: if (tick) begin
          par_ok_q <= (^sr_q ^ s2_q) == par_odd_q;
          state_q  <= STOP;
          cnt_q    <= baud_q - BAUD_W'(1);
        end
`endif
        STOP: if (tick) begin
          state_q    <= IDLE;
          rx_data_q  <= frame_ok ? sr_q : rx_data_q;
          byte_rdy_q <= frame_ok;
          frm_err_q  <= ~frame_ok;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  for (genvar g = 0; g < NMATCH; g++) begin : g_hit
    assign hit[g] = ((rx_data_q ^ bus.match_i[g*DATA_W +: DATA_W]) & ~bus.mask_i[g*DATA_W +: DATA_W]) == '0;
  end
  // A miss that still matches the first word restarts the sequence at word 1.
  always_comb begin
    idx_d  = idx_q;
    trig_d = trig_q;
    if (!bus.armed_i) begin
      idx_d  = '0;
      trig_d = 1'b0;
    end else if (frm_err_q) idx_d = '0;
    else if (byte_rdy_q) begin
      if (hit[idx_q] && idx_q == IW'(NMATCH - 1)) begin
        idx_d  = '0;
        trig_d = 1'b1;
      end else if (hit[idx_q]) idx_d = idx_q + IW'(1);
      else if (hit[0]) begin
        idx_d  = IW'(NMATCH > 1);
        trig_d = trig_q | (NMATCH == 1);
      end else idx_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {idx_q, trig_q} <= '0;
    else {idx_q, trig_q} <= {idx_d, trig_d};
  assign bus.rx_data_o   = rx_data_q;
  assign bus.byte_rdy_o  = byte_rdy_q;
  assign bus.frm_err_o   = frm_err_q;
  assign bus.triggered_o = trig_q;
endmodule

// File: doc/uart_seq_trig.md
Name: uart_seq_trig

Overview:
- Parametrised UART protocol trigger for the LA_dig channel path; successor to the fixed single-byte UART trigger.
- Oversamples one serial channel and decodes frames of configurable data width.
- Asserts a sticky trigger when a programmable sequence of 1..NMATCH masked words arrives back-to-back.
- Sits between the channel mux (CH1 synchronised input) and trigger logic; configured from LA registers.

Parameters:
DATA_W, 8, data bits per frame, legal 5..9
NMATCH, 2, words in match sequence, legal 1..4
BAUD_W, 16, width of bit-period count

Ports:
clk  input  1  system clock (100MHz)
rst_n  input  1  asynchronous active-low reset
RX  input  1  serial line, asynchronous to clk
baud_cnt  input  BAUD_W  clk cycles per bit, minimum 4
match  input  NMATCH*DATA_W  match words; slice 0 (LSBs) = first word expected
mask  input  NMATCH*DATA_W  1 = bit don't-care
armed  input  1  enable matcher
rx_data  output  DATA_W  last valid word received
byte_rdy  output  1  one-cycle pulse per valid word
frm_err  output  1  one-cycle pulse on bad stop bit
triggered  output  1  sticky sequence-match flag

Behaviour:
- Reset values: rx_data=0, byte_rdy=0, frm_err=0, triggered=0, sequence index=0, state IDLE; RX synchroniser flops reset to 1.
- RX passes a 2-flop synchroniser; edge detect uses synchronised value plus one more flop.
- baud_cnt latched into a local register on start-edge detect; changes mid-frame are ignored.
- IDLE: falling edge -> START, counter = baud_cnt>>1.
- START: at counter 0, sampled RX=0 -> DATA, counter = baud_cnt, bit index 0. RX=1 (glitch) -> IDLE, no outputs.
- DATA: sample at each counter expiry, LSB first, shift into DATA_W register; after DATA_W samples -> STOP (or PARITY, see optional feature).
- STOP: sample at expiry.
  - 1: rx_data loads word, byte_rdy pulses one cycle.
  - 0: frm_err pulses, rx_data unchanged, sequence index -> 0.
  - Either case -> IDLE. A new start edge is recognised from the cycle after the pulse.
- Matcher acts on each byte_rdy, comparing (word ^ match[idx]) & ~mask[idx] == 0:
  - hit, idx==NMATCH-1: triggered set on the next clk; idx -> 0.
  - hit, idx<NMATCH-1: idx+1.
  - miss: if word matches slice 0, idx -> 1 (or trigger if NMATCH==1); else idx -> 0.
- Latency: triggered rises exactly 1 clk after the byte_rdy of the final word.
- triggered stays high until armed=0.
- armed=0: idx and triggered held at 0; receiver still runs and byte_rdy/rx_data still update.
- armed rising mid-frame: that frame is still eligible as word 0.
- No inter-word timeout; arbitrary idle time between words.
- rst_n assertion mid-frame aborts immediately to reset values.

Optional Feature:
- Macro: UART_SEQ_TRIG_PARITY_EN
- Defined:
  - Adds inputs parity_en (1) and parity_odd (1), latched with baud_cnt at start.
  - When parity_en=1, a PARITY state follows DATA and samples one extra bit.
  - Parity mismatch is treated exactly like a stop-bit error: frm_err pulse, word discarded, idx -> 0.
- Undefined: ports and PARITY state absent; frames are start + DATA_W + stop only.

Test Plan:
1. NMATCH=1, DATA_W=8, baud_cnt=16, match=8'h96, mask=0, armed=1; send 0x96 -> byte_rdy pulse, rx_data=8'h96, triggered=1 one clk later; stays 1 until armed=0, then 0.
2. NMATCH=2, match slice0=8'hBE, slice1=8'hEF; send BE,12,EF -> no trigger. Send BE,BE,EF -> triggered after EF (restart rule).
3. NMATCH=1, match=8'h90, mask=8'h0F; send 0x9C -> triggered. Send 0xAC -> not triggered.
4. baud_cnt=16, RX low for 4 clks then high -> no byte_rdy, no frm_err; next valid 0x55 frame decoded correctly.
5. Frame 0xBE with stop bit forced 0, mid-sequence at idx=1 -> frm_err pulse, no byte_rdy, rx_data unchanged, idx=0 (a following EF does not trigger).
6. rst_n low during DATA bit 3 -> all outputs 0 within reset; after release, send 0x96 -> rx_data=8'h96 and trigger per test 1.
